if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 62 ++++++
 tb/tb_if_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch FSM with redirect handling
module if_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        id_ready,
   input  logic        redirect_en,
   input  logic [63:0] redirect_pc
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
   state_t state, state_n;
   logic [63:0] pc, pc_n, inst_pc_n;
   logic [31:0] inst_n;
   assign imem_req = state == REQ;
   assign imem_addr = pc;
   assign inst_valid = state == HOLD;
   always_comb begin
      state_n = state;
      pc_n = pc;
      inst_n = inst;
      inst_pc_n = inst_pc;
      if (redirect_en) begin
         pc_n = redirect_pc & ~64'd3;
         // a granted request whose response is still owed must be drained in DROP
         state_n = (((state == WAIT || state == DROP) && !imem_rvalid) || (state == REQ && imem_gnt)) ? DROP : REQ;
      end else
         case (state)
            IDLE: state_n = REQ;
            REQ:  state_n = imem_gnt ? WAIT : REQ;
            WAIT: if (imem_rvalid) begin
               state_n = HOLD;
               inst_n = imem_rdata;
               inst_pc_n = pc;
               pc_n = pc + 64'd4;
            end
            HOLD: state_n = id_ready ? REQ : HOLD;
            DROP: state_n = imem_rvalid ? REQ : DROP;
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         inst <= 32'h0;
         inst_pc <= 64'h0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         inst <= inst_n;
         inst_pc <= inst_pc_n;
      end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and random fetch traffic checked against a transaction-level model
module tb_if_fetch;
   logic clk = 1'b0, rst = 1'b1;
   logic imem_gnt = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b0, redirect_en = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [63:0] redirect_pc = 64'h0;
   logic imem_req, inst_valid, imem_req_2, inst_valid_2;
   logic [63:0] imem_addr, inst_pc, imem_addr_2, inst_pc_2;
   logic [31:0] inst, inst_2;

   if_fetch dut (.clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .id_ready(id_ready), .redirect_en(redirect_en), .redirect_pc(redirect_pc));
   if_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_2 (.clk(clk), .rst(rst), .imem_req(imem_req_2),
      .imem_addr(imem_addr_2), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid_2), .inst(inst_2), .inst_pc(inst_pc_2), .id_ready(id_ready),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   // model: next fetch address, held instruction, one outstanding request (possibly stale)
   logic m_idle, m_held, m_out, m_stale;
   logic [63:0] m_pc, m_out_addr, m_ipc;
   logic [31:0] m_inst;
   // memory: pending response with countdown
   logic mem_pend;
   int mem_cnt, lat;
   logic chk2 = 1'b0;
   logic [63:0] n2;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic mreq();
      return !m_idle && !m_held && !m_out;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      {imem_gnt, imem_rvalid, id_ready, redirect_en} = 4'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
      chk("rst_req_2", 64'(imem_req_2), 64'd0);
      rst = 1'b0;
      m_idle = 1'b1; m_held = 1'b0; m_out = 1'b0; m_stale = 1'b0;
      m_pc = 64'h0000_0000_8000_0000; m_out_addr = 64'h0; m_ipc = 64'h0; m_inst = 32'h0;
      mem_pend = 1'b0; mem_cnt = 0;
   endtask

   // one clock: check outputs at negedge, drive inputs, advance model at posedge
   task automatic cyc(input logic g, input logic idr, input logic re, input logic [63:0] rp, input logic spur);
      logic er, rv, oo, oh, g2;
      er = mreq();
      chk("imem_req", 64'(imem_req), 64'(er));
      if (er) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(m_held));
      chk("inst", 64'(inst), 64'(m_inst));
      chk("inst_pc", inst_pc, m_ipc);
      g2 = imem_req_2 && g;
      if (chk2 && imem_req_2) chk("imem_addr_2", imem_addr_2, 64'hFFFF_FFFF_FFFF_FFFC + n2 * 64'd4);
      rv = (mem_pend && mem_cnt == 0) || (spur && !mem_pend);
      imem_gnt = g; imem_rvalid = rv; imem_rdata = $urandom; id_ready = idr;
      redirect_en = re; redirect_pc = rp;
      @(posedge clk);
      if (g2) n2 += 64'd1;
      oo = m_out; oh = m_held;
      m_idle = 1'b0;
      if (oo && rv) begin
         if (!m_stale && !re) begin
            m_held = 1'b1; m_inst = imem_rdata; m_ipc = m_out_addr; m_pc = m_out_addr + 64'd4;
         end
         m_out = 1'b0;
      end
      if (er && g) begin
         m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc;
      end
      if (oh && idr) m_held = 1'b0;
      if (re) begin
         m_pc = {rp[63:2], 2'b00};
         m_held = 1'b0;
         if (m_out) m_stale = 1'b1;
      end
      if (mem_pend && mem_cnt == 0 && rv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (er && g) begin
         mem_pend = 1'b1; mem_cnt = lat - 1;
      end
      @(negedge clk);
   endtask

   task automatic to_req();
      for (int k = 0; k < 12 && !mreq(); k++) cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic to_wait();
      to_req();
      cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic to_hold();
      to_wait();
      for (int k = 0; k < 12 && !m_held; k++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
   endtask

   initial begin
      lat = 1;
      n2 = 64'd0;
      do_reset();
      chk2 = 1'b1;
      repeat (9) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk2 = 1'b0;
      chk("fetches_2", n2, 64'd3);
      to_req();
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      repeat (4) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      to_hold();
      repeat (5) cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      lat = 3;
      to_wait();
      cyc(1'b1, 1'b1, 1'b1, 64'h8000_1002, 1'b0);
      repeat (6) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      lat = 1;
      to_hold();
      cyc(1'b1, 1'b1, 1'b1, 64'h8000_2000, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      to_wait();
      cyc(1'b0, 1'b1, 1'b1, 64'h8000_3001, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      to_req();
      cyc(1'b1, 1'b1, 1'b1, 64'h8000_4003, 1'b0);
      repeat (4) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      lat = 3;
      to_wait();
      cyc(1'b0, 1'b1, 1'b1, 64'h8000_5000, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 64'h8000_6000, 1'b0);
      repeat (5) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      lat = 1;
      to_hold();
      cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      lat = 4;
      to_wait();
      do_reset();
      repeat (8) cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) do_reset();
         else begin
            lat = $urandom_range(4, 1);
            cyc(1'($urandom_range(1)), $urandom_range(9) < 6, $urandom_range(99) < 8,
               {$urandom, $urandom}, $urandom_range(19) == 0);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
